// File: rtl/uart_tx_cfg_if.sv
// Purpose: producer-to-UART handshake bundle (character, valid/ready) plus line and status outputs.
// Latency: none, wires only.
// Backpressure: o_ready from the transmitter gates i_valid from the producer.
// Ports: i_data/i_valid driven by the producer (master); o_ready/o_tx/o_busy/o_done driven by the transmitter (slave).
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_tx,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_tx,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Purpose: parametrised UART transmitter (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Latency: start bit on o_tx the edge after accept; frame lasts DIV*(1+DATA_BITS+parity+STOP_BITS) clocks.
// Backpressure: o_ready high only in IDLE; i_valid outside IDLE is ignored, never queued.
// Ports: clk, rst_n (synchronous, active low); bus = uart_tx_cfg_if.slave carrying
//        i_data, i_valid (in) and o_ready, o_tx, o_busy, o_done (out).
module uart_tx_cfg #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_cfg_if.slave bus
);

  localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  // Reject unsupported configurations at elaboration.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.i_valid) begin
        // Accept: baud timing restarts here so the start bit is a full DIV clocks.
        shift_d = bus.i_data;
        par_d   = (PARITY == 1) ? ~^bus.i_data : ^bus.i_data;
        state_d = S_START;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      // Bit boundary: the line level for the next bit is loaded on this same
      // edge as the state change, so o_tx never lags the state.
      cnt_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
        S_DATA: begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // Next data bit is shift_q[1]; it becomes shift_q[0] after the shift.
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
        S_STOP: begin
          // bit_q counts stop bits here, reusing the data bit counter.
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Also aborts a frame in flight; no done pulse is produced.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_tx    = tx_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule
